// File: rtl/isp_frame_sequencer.sv
// Frame sequencer at the head of the ISP pipeline. It issues the SOF pulse, forwards rows with fixed
// blanking, then flushes zero rows until the pipeline drains. Optional flush timeout: ISP_SEQ_TIMEOUT_EN.
module isp_frame_sequencer #(
  parameter int WIDTH          = 320,
  parameter int HEIGHT         = 240,
  parameter int DW             = 8,
  parameter int HBLANK         = 16,
  parameter int SOF_CYCLES     = 32,
  parameter int MAX_FLUSH_ROWS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      iStart,
  input  logic                      iValid,
  input  logic [DW-1:0]             iData,
  output logic                      oReady,
  output logic                      newFrame,
  output logic                      oValid,
  output logic [DW-1:0]             oData,
  input  logic                      iPipeDone,
  output logic                      oBusy,
  output logic                      oFrameDone,
  output logic                      oError,
  output logic [$clog2(HEIGHT)-1:0] oRow,
  output logic [$clog2(WIDTH)-1:0]  oCol,
  output logic [2:0]                dbg_state
);
  localparam int CW      = $clog2(WIDTH);
  localparam int RW      = $clog2(HEIGHT);
  localparam int CNT_A   = (SOF_CYCLES > HBLANK) ? SOF_CYCLES : HBLANK;
  localparam int CNT_MAX = (CNT_A > MAX_FLUSH_ROWS) ? CNT_A : MAX_FLUSH_ROWS;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOF    = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_FLUSH  = 3'd4,
    S_FBLANK = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            done_seen;
  logic            accept, done_eff, last_col, last_row;
  logic            sof_end, blank_end, timeout;

  // Source handshake: a pixel moves only when iValid and oReady are both high in the same cycle.
  assign accept    = (state == S_ACTIVE) && iValid;
  assign done_eff  = done_seen || iPipeDone;
  assign last_col  = (col == CW'(WIDTH - 1));
  assign last_row  = (row == RW'(HEIGHT - 1));
  assign sof_end   = (cnt == CNTW'(SOF_CYCLES - 1));
  assign blank_end = (cnt == CNTW'(HBLANK - 1));

  assign oReady     = (state == S_ACTIVE);
  assign newFrame   = (state == S_SOF) && (cnt == '0);
  assign oBusy      = (state != S_IDLE);
  assign oFrameDone = (state == S_DONE);
  assign oRow       = row;
  assign oCol       = col;
  assign dbg_state  = state;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (iStart) state_n = S_SOF;
      S_SOF:    if (sof_end) state_n = S_ACTIVE;
      S_ACTIVE: if (accept && last_col) state_n = last_row ? S_FLUSH : S_HBLANK;
      S_HBLANK: if (blank_end) state_n = S_ACTIVE;
      S_FLUSH: begin
        if (last_col) begin
          if (done_eff || timeout) state_n = S_DONE;
          else                     state_n = S_FBLANK;
        end
      end
      S_FBLANK: if (blank_end) state_n = done_eff ? S_DONE : S_FLUSH;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      col       <= '0;
      row       <= '0;
      done_seen <= 1'b0;
      oValid    <= 1'b0;
      oData     <= '0;
    end else begin
      state  <= state_n;
      oValid <= accept || (state == S_FLUSH);
      oData  <= accept ? iData : '0;

      // One counter times SOF and both blank intervals; it restarts on every state change.
      if (state_n != state)
        cnt <= '0;
      else if (state == S_SOF || state == S_HBLANK || state == S_FBLANK)
        cnt <= cnt + 1'b1;

      if (state == S_IDLE && iStart) begin
        row <= '0;
        col <= '0;
      end else if (accept) begin
        col <= last_col ? '0 : col + 1'b1;
        if (last_col && !last_row) row <= row + 1'b1;
      end else if (state == S_FLUSH) begin
        col <= last_col ? '0 : col + 1'b1;
      end

      if (state == S_DONE)
        done_seen <= 1'b0;
      else if ((state == S_FLUSH || state == S_FBLANK) && iPipeDone)
        done_seen <= 1'b1;
    end
  end

`ifdef ISP_SEQ_TIMEOUT_EN
  logic [CNTW-1:0] flush_rows;
  logic            err_q;

  assign timeout = (flush_rows == CNTW'(MAX_FLUSH_ROWS - 1));
  assign oError  = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_rows <= '0;
      err_q      <= 1'b0;
    end else if (state == S_IDLE && iStart) begin
      flush_rows <= '0;
      err_q      <= 1'b0;
    end else if (state == S_FLUSH && last_col) begin
      flush_rows <= flush_rows + 1'b1;
      if (timeout && !done_eff) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign oError  = 1'b0;
`endif

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// Bench for isp_frame_sequencer: cycle vector table for a full frame, directed corner sequences,
// and randomized frames scored against a transaction-level model.
module tb_isp_frame_sequencer;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int DW   = 8;
  localparam int HB   = 2;
  localparam int SOFC = 3;
  localparam int MFR  = 3;
  localparam int SLOT = W + HB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iStart = 1'b0;
  logic          iValid = 1'b0;
  logic [DW-1:0] iData = '0;
  logic          iPipeDone = 1'b0;
  logic          oReady, newFrame, oValid, oBusy, oFrameDone, oError;
  logic [DW-1:0] oData;
  logic [1:0]    oRow, oCol;
  logic [2:0]    dbg_state;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic st, vl; logic [7:0] dt; logic pd;
    logic rdy, nf, ov; logic [7:0] od; logic bsy, fd; logic [1:0] rw, cl;
  } vec_t;
  vec_t tv[$];

  isp_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .DW(DW), .HBLANK(HB), .SOF_CYCLES(SOFC),
                        .MAX_FLUSH_ROWS(MFR)) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .iValid(iValid), .iData(iData),
    .oReady(oReady), .newFrame(newFrame), .oValid(oValid), .oData(oData),
    .iPipeDone(iPipeDone), .oBusy(oBusy), .oFrameDone(oFrameDone), .oError(oError),
    .oRow(oRow), .oCol(oCol), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic st, vl, input logic [7:0] dt, input logic pd,
                         input logic rdy, nf, ov, input logic [7:0] od, input logic bsy, fd,
                         input logic [1:0] rw, cl);
    vec_t v;
    v = '{st, vl, dt, pd, rdy, nf, ov, od, bsy, fd, rw, cl};
    tv.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    for (int t = 0; t < 50 && !oReady; t++) step();
    chk(name, oReady, 1);
  endtask

  task automatic monitor();
    if (oValid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand_extra_valid: got oValid=1 with data %0h required no output", oData);
      end else begin
        chk("rand_data", oData, exp_q.pop_front());
      end
    end
  endtask

  // Model: pixels leave in acceptance order; the flush length is set by which flush slot
  // (row plus its trailing blank) first sees iPipeDone.
  task automatic run_random_frame(input int d);
    logic [DW-1:0] px[W*H];
    logic acc;
    int p, gap, k, pos, fd_step, fd_seen;
    k = d / SLOT + 1;
    pos = d % SLOT;
    fd_step = (pos < W) ? (k - 1) * SLOT + W : k * SLOT;
    for (int i = 0; i < W * H; i++) begin
      px[i] = DW'($urandom_range(0, 255));
      exp_q.push_back(px[i]);
    end
    iStart = 1'b1; iValid = 1'b0;
    step();
    monitor();
    iStart = 1'b0;
    p = 0; gap = 0;
    for (int t = 0; t < 2000 && p < W * H; t++) begin
      iValid = ($urandom_range(0, 3) != 0);
      iData = px[p];
      acc = iValid && oReady;
      if (acc) begin
        chk("rand_col", oCol, p % W);
        chk("rand_row", oRow, p / W);
      end
      if (p > 0 && !oReady) gap++;
      else if (gap > 0) begin
        chk("rand_hblank_len", gap, HB);
        gap = 0;
      end
      step();
      monitor();
      if (acc) p++;
    end
    chk("rand_accepts", p, W * H);
    for (int i = 0; i < W * k; i++) exp_q.push_back('0);
    fd_seen = 0;
    for (int s = 0; s < 200 && fd_seen == 0; s++) begin
      iValid = 1'($urandom_range(0, 1));
      iData = DW'($urandom_range(0, 255));
      iPipeDone = (s == d);
      step();
      monitor();
      if (oFrameDone) fd_seen = s + 1;
    end
    iPipeDone = 1'b0; iValid = 1'b0;
    chk("rand_done_step", fd_seen, fd_step);
    chk("rand_error", oError, 0);
    step();
    monitor();
    chk("rand_idle_busy", oBusy, 0);
    chk("rand_queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int p, nv, nfd, nerr, nidle, fd_at;
    logic acc;

    // Full frame: start, three rows with iValid held, two flush rows, done pulse, ignored iStart in DONE.
    add_vec(1,0,8'd0,0,   0,1,0,8'd0,1,0,0,0);
    add_vec(0,1,8'd1,0,   0,0,0,8'd0,1,0,0,0);
    add_vec(0,1,8'd1,0,   0,0,0,8'd0,1,0,0,0);
    add_vec(0,1,8'd1,0,   1,0,0,8'd0,1,0,0,0);
    add_vec(0,1,8'd1,0,   1,0,1,8'd1,1,0,0,1);
    add_vec(0,1,8'd2,0,   1,0,1,8'd2,1,0,0,2);
    add_vec(0,1,8'd3,0,   1,0,1,8'd3,1,0,0,3);
    add_vec(0,1,8'd4,0,   0,0,1,8'd4,1,0,1,0);
    add_vec(0,1,8'd5,0,   0,0,0,8'd0,1,0,1,0);
    add_vec(0,1,8'd5,0,   1,0,0,8'd0,1,0,1,0);
    add_vec(0,1,8'd5,0,   1,0,1,8'd5,1,0,1,1);
    add_vec(0,1,8'd6,0,   1,0,1,8'd6,1,0,1,2);
    add_vec(0,1,8'd7,0,   1,0,1,8'd7,1,0,1,3);
    add_vec(0,1,8'd8,0,   0,0,1,8'd8,1,0,2,0);
    add_vec(0,1,8'd9,0,   0,0,0,8'd0,1,0,2,0);
    add_vec(0,1,8'd9,0,   1,0,0,8'd0,1,0,2,0);
    add_vec(0,1,8'd9,0,   1,0,1,8'd9,1,0,2,1);
    add_vec(0,1,8'd10,0,  1,0,1,8'd10,1,0,2,2);
    add_vec(0,1,8'd11,0,  1,0,1,8'd11,1,0,2,3);
    add_vec(0,1,8'd12,0,  0,0,1,8'd12,1,0,2,0);
    add_vec(0,1,8'hAA,0,  0,0,1,8'd0,1,0,2,1);
    add_vec(0,1,8'hAA,0,  0,0,1,8'd0,1,0,2,2);
    add_vec(0,1,8'hAA,0,  0,0,1,8'd0,1,0,2,3);
    add_vec(0,1,8'hAA,0,  0,0,1,8'd0,1,0,2,0);
    add_vec(0,0,8'd0,0,   0,0,0,8'd0,1,0,2,0);
    add_vec(0,0,8'd0,0,   0,0,0,8'd0,1,0,2,0);
    add_vec(0,0,8'd0,1,   0,0,1,8'd0,1,0,2,1);
    add_vec(0,0,8'd0,0,   0,0,1,8'd0,1,0,2,2);
    add_vec(0,0,8'd0,0,   0,0,1,8'd0,1,0,2,3);
    add_vec(0,0,8'd0,0,   0,0,1,8'd0,1,1,2,0);
    add_vec(1,0,8'd0,0,   0,0,0,8'd0,0,0,2,0);
    add_vec(0,0,8'd0,0,   0,0,0,8'd0,0,0,2,0);

    step(); step();
    reset = 1'b0;
    chk("reset_ready", oReady, 0);
    chk("reset_newframe", newFrame, 0);
    chk("reset_valid", oValid, 0);
    chk("reset_data", oData, 0);
    chk("reset_busy", oBusy, 0);
    chk("reset_done", oFrameDone, 0);
    chk("reset_error", oError, 0);
    chk("reset_row", oRow, 0);
    chk("reset_col", oCol, 0);

    for (int i = 0; i < tv.size(); i++) begin
      iStart = tv[i].st; iValid = tv[i].vl; iData = tv[i].dt; iPipeDone = tv[i].pd;
      step();
      chk($sformatf("vec%0d_ready", i), oReady, tv[i].rdy);
      chk($sformatf("vec%0d_newframe", i), newFrame, tv[i].nf);
      chk($sformatf("vec%0d_valid", i), oValid, tv[i].ov);
      if (tv[i].ov) chk($sformatf("vec%0d_data", i), oData, tv[i].od);
      chk($sformatf("vec%0d_busy", i), oBusy, tv[i].bsy);
      chk($sformatf("vec%0d_framedone", i), oFrameDone, tv[i].fd);
      chk($sformatf("vec%0d_row", i), oRow, tv[i].rw);
      chk($sformatf("vec%0d_col", i), oCol, tv[i].cl);
    end
    iStart = 1'b0; iValid = 1'b0; iPipeDone = 1'b0;

    // Source stalls for three cycles at column 2; the row still needs four accepts.
    iStart = 1'b1; step(); iStart = 1'b0;
    wait_ready("stall_ready");
    iValid = 1'b1; iData = 8'h21; step();
    iData = 8'h22; step();
    chk("stall_col_before", oCol, 2);
    iValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_valid", oValid, 0);
      chk("stall_col_hold", oCol, 2);
      chk("stall_ready_hold", oReady, 1);
    end
    iValid = 1'b1; iData = 8'h23; step();
    chk("stall_col3", oCol, 3);
    chk("stall_data3", oData, 8'h23);
    iData = 8'h24; step();
    chk("stall_row_end_ready", oReady, 0);
    chk("stall_row_end_row", oRow, 1);
    chk("stall_row_end_valid", oValid, 1);
    chk("stall_row_end_data", oData, 8'h24);

    // Reset in the middle of row 1 aborts the frame; a fresh start begins at row 0.
    iValid = 1'b0;
    wait_ready("abort_ready");
    iValid = 1'b1; step(); step();
    chk("abort_pre_row", oRow, 1);
    chk("abort_pre_col", oCol, 2);
    reset = 1'b1; step(); reset = 1'b0; iValid = 1'b0;
    chk("abort_valid", oValid, 0);
    chk("abort_ready_low", oReady, 0);
    chk("abort_busy", oBusy, 0);
    chk("abort_row", oRow, 0);
    chk("abort_col", oCol, 0);
    iStart = 1'b1; step(); iStart = 1'b0;
    chk("restart_newframe", newFrame, 1);
    chk("restart_row", oRow, 0);
    chk("restart_col", oCol, 0);

    // The restarted frame runs with the pipeline never reporting done.
    p = 0;
    for (int t = 0; t < 200 && p < W * H; t++) begin
      iValid = 1'b1;
      acc = oReady;
      step();
      if (acc) p++;
    end
    iValid = 1'b0;
    chk("nodone_accepts", p, W * H);
    nv = 0; nfd = 0; nerr = 0; nidle = 0; fd_at = 0;
`ifdef ISP_SEQ_TIMEOUT_EN
    for (int s = 0; s < 60 && fd_at == 0; s++) begin
      step();
      if (oValid) nv++;
      if (oFrameDone) fd_at = s + 1;
    end
    chk("timeout_done_step", fd_at, (MFR - 1) * SLOT + W);
    chk("timeout_flush_valids", nv, MFR * W);
    chk("timeout_error", oError, 1);
    step();
    chk("timeout_idle_busy", oBusy, 0);
    chk("timeout_error_sticky", oError, 1);
    step();
    chk("timeout_error_sticky2", oError, 1);
    iStart = 1'b1; step(); iStart = 1'b0;
    chk("timeout_error_cleared", oError, 0);
    chk("timeout_restart_newframe", newFrame, 1);
`else
    for (int s = 0; s < 10 * SLOT; s++) begin
      step();
      if (oValid) nv++;
      if (oFrameDone) nfd++;
      if (oError) nerr++;
      if (!oBusy) nidle++;
    end
    chk("nodone_flush_valids", nv, 10 * W);
    chk("nodone_no_framedone", nfd, 0);
    chk("nodone_error", nerr, 0);
    chk("nodone_busy", nidle, 0);
`endif
    reset = 1'b1; step(); reset = 1'b0; step();

    for (int f = 0; f < 20; f++) run_random_frame($urandom_range(0, MFR * SLOT - HB - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
